ov_dvp_tx: RTL and testbench
============================

# ov_dvp_tx

Camera-side DVP (OV-style) transmitter: serialises RGB565 pixels into the 8-bit `vsync`/`href`/`data` byte stream an OV sensor drives, high byte first.
- Sits opposite the sensor capture/decode path, so the capture chain (decode → RGB888 → vid_in) can be exercised on-board or in simulation without a physical camera.
- Pixels come from an upstream ready/valid source or, optionally, an internal colour-bar generator.

## Interface
Parameters:
- `H_ACTIVE`, 640, active pixels per line (even, multiple of 8)
- `H_BLANK`, 144, clocks of `href` low per line (≥2)
- `V_ACTIVE`, 480, active lines per frame
- `VSYNC_LINES`, 3, lines with `cmos_vsync_o` high
- `V_BACK`, 17, blank lines after vsync, before active
- `V_FRONT`, 10, blank lines after active

Ports (one clock; reset is synchronous and active-high):
- `CLK_i`  in  1  byte clock; every cycle carries one byte slot
- `rst_i`  in  1  synchronous active-high reset
- `enable_i`  in  1  run request; sampled only in IDLE and at the end of a frame
- `pattern_sel_i`  in  1  1 = internal colour bars (only with `OV_TX_COLORBAR_EN`)
- `pix_data_i`  in  16  RGB565 pixel {R[15:11],G[10:5],B[4:0]}
- `pix_valid_i`  in  1  upstream pixel valid
- `pix_ready_o`  out  1  pixel accepted this cycle when high together with valid
- `cmos_pclk_o`  out  1  forwarded pixel clock = ~CLK_i, so the rising edge is mid-eye
- `cmos_vsync_o`  out  1  frame sync, active high
- `cmos_href_o`  out  1  line data valid
- `cmos_data_o`  out  8  byte stream
- `frame_start_o`  out  1  one-cycle pulse on the first VSYNC cycle
- `underflow_o`  out  1  sticky; set on an underrun, cleared by reset only

## Operation
- Line length is L = 2*H_ACTIVE + H_BLANK clocks.
  - `h` counts 0..L-1; `v` counts lines within the current state.
  - Both counters wrap to 0 when they reach their limit.
- FSM states: IDLE → VSYNC (VSYNC_LINES) → VBACK (V_BACK) → ACTIVE (V_ACTIVE) → VFRONT (V_FRONT).
  - At the end of VFRONT: go to VSYNC if `enable_i`=1, else go to IDLE.
  - In IDLE: go to VSYNC in the cycle after `enable_i`=1 is seen. `h` and `v` are cleared.
  - A state whose line count is 0 is skipped.
- `cmos_vsync_o`=1 throughout VSYNC only.
- `cmos_href_o`=1 only in ACTIVE with h < 2*H_ACTIVE. Otherwise `cmos_data_o`=0x00.
- Byte order per pixel:
  - even h: `cmos_data_o` = pix[15:8]
  - odd h: `cmos_data_o` = pix[7:0]
- Pixel fetch:
  - `pix_ready_o`=1 in the cycle before each even-h active byte is registered out.
  - The pixel is latched on that edge and held for both bytes.
  - If `pix_valid_i`=0 when `pix_ready_o`=1: send 0x0000 for that pixel, set `underflow_o`, do not stall the timing.
- Colour bars (compiled in and `pattern_sel_i`=1):
  - bar index = pixel_x / (H_ACTIVE/8), giving 8 equal-width bars.
  - Bar colours in index order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - `pix_ready_o` is held 0 and upstream is ignored.
- `pattern_sel_i` is sampled at frame start only.
- Deasserting `enable_i` mid-frame does not truncate the frame; the current frame completes.

## Timing
- All outputs are registered except `cmos_pclk_o`.
- Reset values: `cmos_vsync_o`, `cmos_href_o`, `cmos_data_o`, `pix_ready_o`, `frame_start_o`, `underflow_o` all 0. FSM = IDLE.
- Reset asserted mid-frame: all of the above are 0 on the next edge, and the counters clear.
- `enable_i`=1 in IDLE at cycle t:
  - `cmos_vsync_o`=1 and `frame_start_o`=1 at t+1.
- First active line:
  - `cmos_href_o` rises at h=0 of that line, together with the first high byte.
  - `pix_ready_o` pulses for that pixel at the last cycle of the preceding line (h=L-1).
- Frame period = L × (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) clocks, with no gap between back-to-back frames.
- Counter widths: sized by `$clog2` of each limit, minimum 1 bit.

## Configuration
- `OV_TX_COLORBAR_EN` defined:
  - Colour-bar generator is compiled in.
  - `pattern_sel_i` selects between colour bars and the upstream source.
- Not defined:
  - Generator is absent and `pattern_sel_i` is ignored.
  - Pixels always come from `pix_data_i`/`pix_valid_i`.
- Port list is identical in both builds.

## Test plan
All scenarios use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. This gives L=20 and a frame of 100 clocks.
- Reset then `enable_i`=1 → `frame_start_o` pulse one cycle later; `cmos_vsync_o` high for exactly 20 clocks; next `frame_start_o` exactly 100 clocks later.
- Upstream always valid, pixels 0x1234, 0x5678, … → each active line carries 16 bytes 12,34,56,78,… with `href` high for 16 clocks, then low for 4 clocks with data 00.
- `pix_valid_i` dropped for one `pix_ready_o` → that pixel is sent as 00,00; `underflow_o` goes to 1 and stays 1; line timing is unchanged.
- With `OV_TX_COLORBAR_EN` and `pattern_sel_i`=1 → line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00; `pix_ready_o` never asserts.
- `enable_i` dropped mid-ACTIVE → the frame completes its 100 clocks, then IDLE with all outputs 0.
- `rst_i` pulsed mid-line → all outputs 0 on the next edge; a restart produces a frame identical to the first.

Source files
------------

// File: rtl/ov_dvp_tx.sv
// OV-style DVP camera-side transmitter: RGB565 pixels out as vsync/href/8-bit bytes, high byte first.
// Optional colour-bar generator compiled in with `OV_TX_COLORBAR_EN.
module ov_dvp_tx #(
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 144,
   parameter int V_ACTIVE    = 480,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10
) (
   input  logic        CLK_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic        pattern_sel_i,
   input  logic [15:0] pix_data_i,
   input  logic        pix_valid_i,
   output logic        pix_ready_o,
   output logic        cmos_pclk_o,
   output logic        cmos_vsync_o,
   output logic        cmos_href_o,
   output logic [7:0]  cmos_data_o,
   output logic        frame_start_o,
   output logic        underflow_o
);

   localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
   localparam int HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam int V_MAX_A  = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
   localparam int V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
   localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
   localparam int VW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;

   localparam logic [HW-1:0] H_LAST     = HW'(LINE_LEN - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(2 * H_ACTIVE);
   localparam logic [HW-1:0] H_ODD_LAST = HW'(2 * H_ACTIVE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VSYNC  = 3'd1,
      S_VBACK  = 3'd2,
      S_ACTIVE = 3'd3,
      S_VFRONT = 3'd4
   } state_t;

   localparam state_t FIRST_STATE = (VSYNC_LINES > 0) ? S_VSYNC :
                                    (V_BACK > 0)      ? S_VBACK :
                                    (V_ACTIVE > 0)    ? S_ACTIVE : S_VFRONT;

   function automatic int lines_in(input state_t s);
      int n;
      case (s)
         S_VSYNC:  n = VSYNC_LINES;
         S_VBACK:  n = V_BACK;
         S_ACTIVE: n = V_ACTIVE;
         S_VFRONT: n = V_FRONT;
         default:  n = 0;
      endcase
      return n;
   endfunction

   // Next non-empty state within the frame; S_IDLE marks the end of the frame.
   function automatic state_t succ(input state_t s);
      state_t r;
      case (s)
         S_VSYNC:  r = (V_BACK > 0) ? S_VBACK : (V_ACTIVE > 0) ? S_ACTIVE :
                       (V_FRONT > 0) ? S_VFRONT : S_IDLE;
         S_VBACK:  r = (V_ACTIVE > 0) ? S_ACTIVE : (V_FRONT > 0) ? S_VFRONT : S_IDLE;
         S_ACTIVE: r = (V_FRONT > 0) ? S_VFRONT : S_IDLE;
         default:  r = S_IDLE;
      endcase
      return r;
   endfunction

   function automatic logic is_last_line(input state_t s, input logic [VW-1:0] v);
      return !(int'(v) < lines_in(s) - 1);
   endfunction

   // State occupied by the line that follows the current one.
   function automatic state_t line_after(input state_t s, input logic [VW-1:0] v,
                                         input logic en);
      state_t r;
      if (s == S_IDLE) begin
         r = S_IDLE;
      end else if (!is_last_line(s, v)) begin
         r = s;
      end else if (succ(s) != S_IDLE) begin
         r = succ(s);
      end else if (en) begin
         r = FIRST_STATE;
      end else begin
         r = S_IDLE;
      end
      return r;
   endfunction

`ifdef OV_TX_COLORBAR_EN
   function automatic logic [15:0] bar_color(input logic [HW-1:0] h);
      logic [2:0]  idx;
      logic [15:0] c;
      idx = 3'((int'(h) / 2) / (H_ACTIVE / 8));
      case (idx)
         3'd0:    c = 16'hFFFF;
         3'd1:    c = 16'hFFE0;
         3'd2:    c = 16'h07FF;
         3'd3:    c = 16'h07E0;
         3'd4:    c = 16'hF81F;
         3'd5:    c = 16'hF800;
         3'd6:    c = 16'h001F;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction
`else
   logic pattern_unused_s;
   assign pattern_unused_s = pattern_sel_i;
`endif

   state_t        state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          fetch_q, fetch_d;
   logic          bar_mode_q, bar_mode_d;
   logic [15:0]   pixel_q, pixel_d;
   logic          pix_ready_q, pix_ready_d;
   logic          vsync_q, vsync_d;
   logic          href_q, href_d;
   logic [7:0]    data_q, data_d;
   logic          frame_start_q, frame_start_d;
   logic          underflow_q, underflow_d;

   // Frame sequencing: state, horizontal and line counters.
   always_comb begin
      state_d       = state_q;
      h_d           = h_q;
      v_d           = v_q;
      frame_start_d = 1'b0;
      if (state_q == S_IDLE) begin
         h_d = {HW{1'b0}};
         v_d = {VW{1'b0}};
         if (enable_i) begin
            state_d       = FIRST_STATE;
            frame_start_d = 1'b1;
         end else begin
            state_d = S_IDLE;
         end
      end else if (h_q == H_LAST) begin
         h_d     = {HW{1'b0}};
         state_d = line_after(state_q, v_q, enable_i);
         if (is_last_line(state_q, v_q)) begin
            v_d           = {VW{1'b0}};
            frame_start_d = (succ(state_q) == S_IDLE) && enable_i;
         end else begin
            v_d = v_q + 1'b1;
         end
      end else begin
         h_d = h_q + 1'b1;
      end
   end

   // Pixel fetch look-ahead, pixel hold and the registered output stream.
   always_comb begin
      fetch_d = 1'b0;
      if (state_d == S_ACTIVE && h_d[0] && (h_d < H_ODD_LAST)) begin
         fetch_d = 1'b1;
      end else if (h_d == H_LAST && line_after(state_d, v_d, enable_i) == S_ACTIVE) begin
         fetch_d = 1'b1;
      end else begin
         fetch_d = 1'b0;
      end

`ifdef OV_TX_COLORBAR_EN
      bar_mode_d = frame_start_d ? pattern_sel_i : bar_mode_q;
`else
      bar_mode_d = 1'b0;
`endif

      pixel_d = pixel_q;
      if (fetch_q) begin
`ifdef OV_TX_COLORBAR_EN
         if (bar_mode_q) begin
            pixel_d = bar_color(h_d);
         end else if (pix_valid_i) begin
            pixel_d = pix_data_i;
         end else begin
            pixel_d = 16'h0000;
         end
`else
         if (pix_valid_i) begin
            pixel_d = pix_data_i;
         end else begin
            pixel_d = 16'h0000;
         end
`endif
      end else begin
         pixel_d = pixel_q;
      end

      underflow_d = underflow_q | (pix_ready_q & ~pix_valid_i);
      pix_ready_d = fetch_d & ~bar_mode_d;
      vsync_d     = (state_d == S_VSYNC);
      href_d      = (state_d == S_ACTIVE) && (h_d < H_ACT_END);
      if (href_d) begin
         data_d = h_d[0] ? pixel_d[7:0] : pixel_d[15:8];
      end else begin
         data_d = 8'h00;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         h_q           <= {HW{1'b0}};
         v_q           <= {VW{1'b0}};
         fetch_q       <= 1'b0;
         bar_mode_q    <= 1'b0;
         pixel_q       <= 16'h0000;
         pix_ready_q   <= 1'b0;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         data_q        <= 8'h00;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_q           <= h_d;
         v_q           <= v_d;
         fetch_q       <= fetch_d;
         bar_mode_q    <= bar_mode_d;
         pixel_q       <= pixel_d;
         pix_ready_q   <= pix_ready_d;
         vsync_q       <= vsync_d;
         href_q        <= href_d;
         data_q        <= data_d;
         frame_start_q <= frame_start_d;
         underflow_q   <= underflow_d;
      end
   end

   assign cmos_pclk_o   = ~CLK_i;
   assign pix_ready_o   = pix_ready_q;
   assign cmos_vsync_o  = vsync_q;
   assign cmos_href_o   = href_q;
   assign cmos_data_o   = data_q;
   assign frame_start_o = frame_start_q;
   assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_ov_dvp_tx.sv
// Scoreboard bench for ov_dvp_tx: a frame-position model predicts every output cycle,
// a monitor pops and compares after each active clock edge.
module tb_ov_dvp_tx;
   localparam int HA = 8, HB = 4, VA = 2, VS = 1, VB = 1, VF = 1;
   localparam int L     = 2 * HA + HB;
   localparam int FRAME = L * (VS + VB + VA + VF);
`ifdef OV_TX_COLORBAR_EN
   localparam bit BAR_BUILD = 1'b1;
`else
   localparam bit BAR_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i = 1'b1, enable_i = 1'b0, pattern_sel_i = 1'b0, pix_valid_i = 1'b0;
   logic [15:0] pix_data_i = 16'h0000;
   logic        pix_ready_o, cmos_pclk_o, cmos_vsync_o, cmos_href_o, frame_start_o, underflow_o;
   logic [7:0]  cmos_data_o;

   ov_dvp_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
               .V_BACK(VB), .V_FRONT(VF)) dut (
      .CLK_i(clk), .rst_i(rst_i), .enable_i(enable_i), .pattern_sel_i(pattern_sel_i),
      .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
      .cmos_pclk_o(cmos_pclk_o), .cmos_vsync_o(cmos_vsync_o), .cmos_href_o(cmos_href_o),
      .cmos_data_o(cmos_data_o), .frame_start_o(frame_start_o), .underflow_o(underflow_o));

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pclk;
      logic       fs;
      logic       vs;
      logic       hr;
      logic [7:0] d;
      logic       rdy;
      logic       uf;
   } obs_t;

   obs_t        exp_q[$];
   int          checks = 0, errors = 0, cyc = 0;
   int          pos = -1;
   logic [15:0] m_pix = 16'h0000;
   bit          m_bar = 1'b0, m_uf = 1'b0;
   logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   function automatic bit in_active_line(int k);
      return (k >= 0) && (k < FRAME) && (k / L >= VS + VB) && (k / L < VS + VB + VA);
   endfunction

   function automatic bit act_even(int k);
      return in_active_line(k) && (k % L < 2 * HA) && (k % 2 == 0);
   endfunction

   task automatic step(input bit en, input bit rst, input bit psel, input int vprob);
      obs_t e;
      @(negedge clk);
      rst_i         = rst;
      enable_i      = en;
      pattern_sel_i = psel;
      pix_valid_i   = ($urandom_range(99) < vprob);
      pix_data_i    = 16'($urandom);
      if (rst) begin
         pos = -1; m_pix = 16'h0000; m_bar = 1'b0; m_uf = 1'b0;
      end else begin
         if (pos >= 0 && act_even(pos + 1)) begin
            if (m_bar) m_pix = bars[(((pos + 1) % L) / 2) / (HA / 8)];
            else begin
               m_pix = pix_valid_i ? pix_data_i : 16'h0000;
               if (!pix_valid_i) m_uf = 1'b1;
            end
         end
         if (pos < 0 || pos == FRAME - 1) pos = en ? 0 : -1;
         else pos = pos + 1;
         if (pos == 0) m_bar = BAR_BUILD && psel;
      end
      e.pclk = 1'b0;
      e.fs   = (pos == 0);
      e.vs   = (pos >= 0) && (pos / L < VS);
      e.hr   = in_active_line(pos) && (pos % L < 2 * HA);
      e.d    = e.hr ? ((pos % 2 == 0) ? m_pix[15:8] : m_pix[7:0]) : 8'h00;
      e.rdy  = (pos >= 0) && !m_bar && act_even(pos + 1);
      e.uf   = m_uf;
      exp_q.push_back(e);
   endtask

   // Monitor: one expected vector per clock, compared just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a.pclk = cmos_pclk_o; a.fs = frame_start_o; a.vs = cmos_vsync_o;
            a.hr = cmos_href_o; a.d = cmos_data_o; a.rdy = pix_ready_o; a.uf = underflow_o;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs cyc=%0d got pclk=%b fs=%b vs=%b href=%b data=%h rdy=%b uf=%b exp pclk=%b fs=%b vs=%b href=%b data=%h rdy=%b uf=%b",
                        cyc, a.pclk, a.fs, a.vs, a.hr, a.d, a.rdy, a.uf,
                        e.pclk, e.fs, e.vs, e.hr, e.d, e.rdy, e.uf);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 100);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 100);
      for (int i = 0; i < 2 * FRAME + 10; i++) step(1'b1, 1'b0, 1'b0, 100);
      for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 1'b0, 85);
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (pos == (VS + VB) * L + 7) break;
         step(1'b1, 1'b0, 1'b0, 100);
      end
      for (int i = 0; i < FRAME + 20; i++) step(1'b0, 1'b0, 1'b0, 90);
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 100);
      step(1'b1, 1'b1, 1'b0, 100);
      for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 1'b0, 1'b0, 100);
      for (int i = 0; i < 2 * FRAME + 5; i++) step(1'b1, 1'b0, 1'b1, 100);
      for (int i = 0; i < 300; i++)
         step($urandom_range(3) != 0, 1'b0, 1'($urandom_range(1)), 80);
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
